// File: rtl/psk_tx_pkg.sv
// Shared definitions for the BPSK/QPSK transmit path: per-byte symbol counts,
// the differential-phase to I/Q sign lookup, and the QPSK phase-increment table.
package psk_tx_pkg;

  localparam logic [3:0] BPSK_SYMS = 4'd8;
  localparam logic [3:0] QPSK_SYMS = 4'd4;

  // Phase (units of 90 degrees) to {negate_i, negate_q}.
  function automatic logic [1:0] phase_signs(input logic [1:0] p);
    logic [1:0] s;
    case (p)
      2'd0:    s = 2'b00;
      2'd1:    s = 2'b10;
      2'd2:    s = 2'b11;
      default: s = 2'b01;
    endcase
    return s;
  endfunction

  // Gray-ordered dibit to phase increment: 00->0, 01->1, 11->2, 10->3.
  function automatic logic [1:0] qpsk_inc(input logic [1:0] dibit);
    logic [1:0] inc;
    case (dibit)
      2'b00:   inc = 2'd0;
      2'b01:   inc = 2'd1;
      2'b11:   inc = 2'd2;
      default: inc = 2'd3;
    endcase
    return inc;
  endfunction

endpackage

// File: rtl/psk_diff_encoder.sv
// Differential encoder for the PSK mapper. Holds the BPSK previous bit and the
// QPSK phase state; produces the I/Q sign for the symbol being emitted and
// advances its state only when a data symbol is actually sent.
module psk_diff_encoder
  import psk_tx_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       advance,
  input  logic       bpsk,
  input  logic [1:0] bits,
  output logic       neg_i,
  output logic       neg_q
);

  logic       d_prev;
  logic [1:0] p;
  logic       d;
  logic [1:0] p_next;
  logic [1:0] signs;

  // Next encoded state and the signs it maps to; BPSK bit arrives in bits[1].
  always_comb begin
    d      = bits[1] ^ d_prev;
    p_next = p + qpsk_inc(bits);
    signs  = phase_signs(p_next);
    neg_i  = bpsk ? d : signs[1];
    neg_q  = bpsk ? 1'b0 : signs[0];
  end

  // State updates only on emitted data symbols; zero symbols leave it alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      d_prev <= 1'b0;
      p      <= 2'd0;
    end else if (advance) begin
      if (bpsk) d_prev <= d;
      else      p      <= p_next;
    end
  end

endmodule

// File: rtl/psk_symbol_mapper.sv
// BPSK/QPSK symbol mapper. Bytes are buffered, serialised MSB-first into 1- or
// 2-bit symbols, mapped to signed I/Q levels and held for SPS clocks each.
// Optional build macro PSK_MAPPER_DIFF_EN enables differential encoding.
//
// Input handshake: a byte is transferred on a clk edge where in_tvalid and
// in_tready are both high; in_tready depends only on registered state and rst.
module psk_symbol_mapper
  import psk_tx_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int SPS      = 8,
  parameter int AMP      = 16384,
  parameter int AMP_QPSK = 11585
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             is_bpsk,
  input  logic [7:0]       in_tdata,
  input  logic             in_tvalid,
  output logic             in_tready,
  output logic [WIDTH-1:0] out_I_tdata,
  output logic             out_I_tvalid,
  output logic [WIDTH-1:0] out_Q_tdata,
  output logic             out_Q_tvalid,
  output logic             symbol_start,
  output logic             underflow,
  output logic             is_bpsk_latched
);

  localparam int CW = (SPS > 1) ? $clog2(SPS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SPS - 1);
  localparam logic [WIDTH-1:0] LVL_BP = WIDTH'(AMP);
  localparam logic [WIDTH-1:0] LVL_BN = WIDTH'(-AMP);
  localparam logic [WIDTH-1:0] LVL_QP = WIDTH'(AMP_QPSK);
  localparam logic [WIDTH-1:0] LVL_QN = WIDTH'(-AMP_QPSK);

  logic [7:0]       buf_data;
  logic             buf_full;
  logic [7:0]       sh;
  logic [3:0]       sh_left;
  logic             sh_bpsk;
  logic [CW-1:0]    cnt;
  logic             tvalid;
  logic             last_data;

  logic             hs;
  logic             boundary;
  logic             load;
  logic             emit;
  logic             sym_bpsk;
  logic [1:0]       bits;
  logic             neg_i;
  logic             neg_q;
  logic [WIDTH-1:0] lvl_i;
  logic [WIDTH-1:0] lvl_q;

  assign in_tready       = !buf_full && !rst;
  assign hs              = in_tvalid && in_tready;
  assign boundary        = (cnt == CNT_LAST);
  assign out_I_tvalid    = tvalid;
  assign out_Q_tvalid    = tvalid;
  assign is_bpsk_latched = sh_bpsk;

  // Pick the symbol source for the next boundary: shift register first, then
  // a fresh load from the buffer (mode sampled now), otherwise a zero symbol.
  always_comb begin
    load     = 1'b0;
    emit     = 1'b0;
    sym_bpsk = sh_bpsk;
    bits     = 2'b00;
    if (sh_left != 4'd0) begin
      emit = 1'b1;
      bits = sh_bpsk ? {sh[7], 1'b0} : sh[7:6];
    end else if (buf_full) begin
      load     = 1'b1;
      emit     = 1'b1;
      sym_bpsk = is_bpsk;
      bits     = is_bpsk ? {buf_data[7], 1'b0} : buf_data[7:6];
    end
  end

`ifdef PSK_MAPPER_DIFF_EN
  psk_diff_encoder u_diff (
    .clk     (clk),
    .rst     (rst),
    .advance (boundary && emit),
    .bpsk    (sym_bpsk),
    .bits    (bits),
    .neg_i   (neg_i),
    .neg_q   (neg_q)
  );
`else
  assign neg_i = bits[1];
  assign neg_q = bits[0];
`endif

  // Map the chosen symbol's signs onto signed I/Q levels (bit 1 means negative).
  always_comb begin
    lvl_i = '0;
    lvl_q = '0;
    if (emit) begin
      if (sym_bpsk) begin
        lvl_i = neg_i ? LVL_BN : LVL_BP;
      end else begin
        lvl_i = neg_i ? LVL_QN : LVL_QP;
        lvl_q = neg_q ? LVL_QN : LVL_QP;
      end
    end
  end

  // Buffer, shift register, symbol timing and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      buf_data     <= '0;
      buf_full     <= 1'b0;
      sh           <= '0;
      sh_left      <= '0;
      sh_bpsk      <= 1'b1;
      cnt          <= CNT_LAST;
      tvalid       <= 1'b0;
      last_data    <= 1'b0;
      out_I_tdata  <= '0;
      out_Q_tdata  <= '0;
      symbol_start <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      symbol_start <= boundary;
      underflow    <= 1'b0;
      if (hs) begin
        buf_data <= in_tdata;
        buf_full <= 1'b1;
      end
      if (boundary) begin
        cnt         <= '0;
        tvalid      <= 1'b1;
        out_I_tdata <= lvl_i;
        out_Q_tdata <= lvl_q;
        last_data   <= emit;
        underflow   <= !emit && last_data;
        if (load) begin
          sh       <= is_bpsk ? {buf_data[6:0], 1'b0} : {buf_data[5:0], 2'b00};
          sh_left  <= (is_bpsk ? BPSK_SYMS : QPSK_SYMS) - 4'd1;
          sh_bpsk  <= is_bpsk;
          buf_full <= 1'b0;
        end else if (sh_left != 4'd0) begin
          sh      <= sh_bpsk ? {sh[6:0], 1'b0} : {sh[5:0], 2'b00};
          sh_left <= sh_left - 4'd1;
        end
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_psk_symbol_mapper.sv
// Self-checking bench for psk_symbol_mapper (SPS=4). Expected symbols are
// queued when a byte handshake completes and compared as symbols appear.
module tb_psk_symbol_mapper;

  localparam int W   = 16;
  localparam int SPS = 4;
  localparam logic signed [W-1:0] A_B = 16384;
  localparam logic signed [W-1:0] A_Q = 11585;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         is_bpsk = 1'b1;
  logic [7:0]   in_tdata = 8'h00;
  logic         in_tvalid = 1'b0;
  logic         in_tready;
  logic [W-1:0] out_i, out_q;
  logic         out_i_valid, out_q_valid;
  logic         symbol_start, underflow, is_bpsk_latched;

  int vectors = 0;
  int miscompares = 0;
  logic [2*W:0] exp_q[$];
  logic [2*W:0] exp_e;
  int data_syms = 0;
  int zero_syms = 0;
  int underflow_cnt = 0;
  int cyc_since = 0;
  bit seen_first = 1'b0;
  logic       tb_dprev = 1'b0;
  logic [1:0] tb_p = 2'd0;

  psk_symbol_mapper #(.WIDTH(W), .SPS(SPS), .AMP(16384), .AMP_QPSK(11585)) dut (
    .clk             (clk),
    .rst             (rst),
    .is_bpsk         (is_bpsk),
    .in_tdata        (in_tdata),
    .in_tvalid       (in_tvalid),
    .in_tready       (in_tready),
    .out_I_tdata     (out_i),
    .out_I_tvalid    (out_i_valid),
    .out_Q_tdata     (out_q),
    .out_Q_tvalid    (out_q_valid),
    .symbol_start    (symbol_start),
    .underflow       (underflow),
    .is_bpsk_latched (is_bpsk_latched)
  );

  // clock
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected symbol stream for one byte, in emission order.
  task automatic push_byte(input logic [7:0] d, input logic mode);
    logic signed [W-1:0] ei, eq;
    logic b, ni, nq;
    logic [1:0] di, inc;
    if (mode) begin
      for (int i = 7; i >= 0; i--) begin
        b = d[i];
`ifdef PSK_MAPPER_DIFF_EN
        b = b ^ tb_dprev;
        tb_dprev = b;
`endif
        ei = b ? -A_B : A_B;
        eq = '0;
        exp_q.push_back({1'b1, ei, eq});
      end
    end else begin
      for (int k = 3; k >= 0; k--) begin
        di = d[2*k+1 -: 2];
        ni = di[1];
        nq = di[0];
`ifdef PSK_MAPPER_DIFF_EN
        case (di)
          2'b00: inc = 2'd0;
          2'b01: inc = 2'd1;
          2'b11: inc = 2'd2;
          default: inc = 2'd3;
        endcase
        tb_p = tb_p + inc;
        case (tb_p)
          2'd0: begin ni = 0; nq = 0; end
          2'd1: begin ni = 1; nq = 0; end
          2'd2: begin ni = 1; nq = 1; end
          default: begin ni = 0; nq = 1; end
        endcase
`else
        inc = 2'd0;
`endif
        ei = ni ? -A_Q : A_Q;
        eq = nq ? -A_Q : A_Q;
        exp_q.push_back({1'b0, ei, eq});
      end
    end
  endtask

  // Driver: present a byte, wait (bounded) for the handshake edge, queue expectations.
  task automatic send_byte(input logic [7:0] d, input logic mode);
    int t;
    t = 0;
    in_tdata  = d;
    in_tvalid = 1'b1;
    while (!in_tready && t < 40 * SPS) begin
      @(negedge clk);
      t++;
    end
    if (!in_tready) begin
      check_eq("handshake_timeout", 0, 1);
    end else begin
      @(posedge clk);
      push_byte(d, mode);
      #1;
    end
    in_tvalid = 1'b0;
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 200 * SPS) begin
      @(negedge clk); #1;
      t++;
    end
    check_eq("drain", exp_q.size(), 0);
  endtask

  task automatic wait_data(input int n);
    int t;
    t = 0;
    while (data_syms < n && t < 200 * SPS) begin
      @(negedge clk); #1;
      t++;
    end
    check_eq("wait_data", data_syms >= n, 1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  // Scoreboard monitor: symbol spacing, data symbols vs expected queue, counters.
  always @(negedge clk) begin
    if (rst) begin
      cyc_since  = 0;
      seen_first = 1'b0;
    end else begin
      cyc_since++;
      if (underflow) underflow_cnt++;
      if (symbol_start) begin
        if (seen_first) check_eq("spacing", cyc_since, SPS);
        seen_first = 1'b1;
        cyc_since  = 0;
        check_eq("tvalid", {out_i_valid, out_q_valid}, 2'b11);
        if (out_i != '0 || out_q != '0) begin
          if (exp_q.size() == 0) begin
            check_eq("unexpected_data", {out_i, out_q}, 0);
          end else begin
            exp_e = exp_q.pop_front();
            check_eq("symbol", {is_bpsk_latched, out_i, out_q}, exp_e);
          end
          data_syms++;
        end else begin
          zero_syms++;
        end
      end
    end
  end

  initial begin : main
    int base, zs0, zs1, uf0, m;

    // reset state
    repeat (3) @(negedge clk);
    check_eq("rst_out", {out_i, out_q}, 0);
    check_eq("rst_tvalid", {out_i_valid, out_q_valid}, 0);
    check_eq("rst_flags", {symbol_start, underflow, in_tready}, 0);
    check_eq("rst_latched", is_bpsk_latched, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_eq("first_start", symbol_start, 1);
    check_eq("first_zero", {out_i, out_q}, 0);
    check_eq("first_tvalid", out_i_valid, 1);
    check_eq("first_ready", in_tready, 1);

    // BPSK 0xA5
    is_bpsk = 1'b1;
    send_byte(8'hA5, 1'b1);
    wait_drain();
    idle(2 * SPS);

    // QPSK 0x1B
    is_bpsk = 1'b0;
    send_byte(8'h1B, 1'b0);
    wait_drain();
    idle(2 * SPS);

    // back-to-back BPSK 0xFF, 0x00: no zero symbol in between
    is_bpsk = 1'b1;
    base = data_syms;
    send_byte(8'hFF, 1'b1);
    send_byte(8'h00, 1'b1);
    check_eq("ready_low_full", in_tready, 0);
    wait_data(base + 1);
    zs0 = zero_syms;
    wait_data(base + 16);
    zs1 = zero_syms;
    check_eq("no_gap", zs1 - zs0, 0);
    wait_drain();
    idle(2 * SPS);

    // mode toggle mid-byte affects only the next load
    base = data_syms;
    send_byte(8'h3C, 1'b1);
    send_byte(8'h96, 1'b0);
    wait_data(base + 3);
    is_bpsk = 1'b0;
    wait_drain();
    check_eq("mode_count", data_syms - base, 12);
    idle(3 * SPS);

    // single byte then idle: exactly one underflow pulse
    uf0 = underflow_cnt;
    is_bpsk = 1'b1;
    send_byte(8'h81, 1'b1);
    wait_drain();
    idle(4 * SPS);
    check_eq("underflow_once", underflow_cnt - uf0, 1);

    // reset mid-byte with a second byte buffered
    send_byte(8'h5A, 1'b1);
    send_byte(8'hC3, 1'b1);
    wait_data(data_syms + 3);
    @(posedge clk); #1;
    rst = 1'b1;
    exp_q.delete();
    tb_dprev = 1'b0;
    tb_p = 2'd0;
    @(posedge clk);
    @(negedge clk);
    check_eq("mid_rst_out", {out_i, out_q}, 0);
    check_eq("mid_rst_tvalid", {out_i_valid, out_q_valid}, 0);
    check_eq("mid_rst_ready", in_tready, 0);
    check_eq("mid_rst_latched", is_bpsk_latched, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    base = data_syms;
    uf0 = underflow_cnt;
    @(posedge clk);
    @(negedge clk);
    check_eq("post_rst_start", symbol_start, 1);
    check_eq("post_rst_zero", {out_i, out_q}, 0);
    idle(12 * SPS);
    check_eq("post_rst_no_data", data_syms - base, 0);
    check_eq("post_rst_no_uf", underflow_cnt - uf0, 0);

`ifdef PSK_MAPPER_DIFF_EN
    is_bpsk = 1'b1;
    send_byte(8'hFF, 1'b1);
    wait_drain();
    is_bpsk = 1'b0;
    send_byte(8'h55, 1'b0);
    wait_drain();
    idle(2 * SPS);
`endif

    // random bursts, one mode per burst
    repeat (4) begin
      m = $urandom_range(0, 1);
      is_bpsk = m[0];
      repeat (4) send_byte(8'($urandom_range(0, 255)), m[0]);
      wait_drain();
      idle(2 * SPS);
    end

    check_eq("queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
